// File: rtl/vga_grayscale_frame_transmitter_if.sv
// Pixel write bus between the edge-detection pipeline and the VGA frame transmitter.
// The producer drives a column/row-tagged grayscale pixel with a write strobe.
interface vga_grayscale_frame_transmitter_if #(
    parameter int P_COLUMN_BITS    = 10,
    parameter int P_ROW_BITS       = 10,
    parameter int P_SUBPIXEL_DEPTH = 8
);
    logic                        I_PIXEL_VALID;
    logic [P_COLUMN_BITS-1:0]    I_PIXEL_COLUMN;
    logic [P_ROW_BITS-1:0]       I_PIXEL_ROW;
    logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL;

    modport master (
        output I_PIXEL_VALID,
        output I_PIXEL_COLUMN,
        output I_PIXEL_ROW,
        output I_PIXEL
    );

    modport slave (
        input I_PIXEL_VALID,
        input I_PIXEL_COLUMN,
        input I_PIXEL_ROW,
        input I_PIXEL
    );
endinterface

// File: rtl/vga_grayscale_frame_transmitter.sv
// VGA frame transmitter: buffers two lines of grayscale pixels in a ping-pong memory
// and emits a VGA stream (pixel clock, syncs, data valid, gray replicated on RGB).
// A line whose last column was not written before its first pixel is shown black
// and raises a sticky underflow flag.
module vga_grayscale_frame_transmitter #(
    parameter int P_H_ACTIVE       = 640,
    parameter int P_H_FRONT        = 16,
    parameter int P_H_SYNC         = 96,
    parameter int P_H_BACK         = 48,
    parameter int P_V_ACTIVE       = 480,
    parameter int P_V_FRONT        = 10,
    parameter int P_V_SYNC         = 2,
    parameter int P_V_BACK         = 33,
    parameter int P_CLKS_PER_PIXEL = 2,
    parameter int P_SUBPIXEL_DEPTH = 8,
    parameter int P_COLUMN_BITS    = $clog2(P_H_ACTIVE + P_H_FRONT + P_H_SYNC + P_H_BACK),
    parameter int P_ROW_BITS       = $clog2(P_V_ACTIVE + P_V_FRONT + P_V_SYNC + P_V_BACK)
) (
    input  logic                            I_CLK,
    input  logic                            I_RESET,
    input  logic                            I_ENABLE,
    input  logic                            I_CLEAR_UNDERFLOW,
    vga_grayscale_frame_transmitter_if.slave pix_bus,
    output logic                            O_PIXEL_CLK,
    output logic                            O_HSYNC,
    output logic                            O_VSYNC,
    output logic                            O_DATA_VALID,
    output logic [3*P_SUBPIXEL_DEPTH-1:0]   O_PIXEL,
    output logic                            O_FRAME_START,
    output logic                            O_UNDERFLOW
);
    localparam int H_TOTAL      = P_H_ACTIVE + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int V_TOTAL      = P_V_ACTIVE + P_V_FRONT + P_V_SYNC + P_V_BACK;
    localparam int DIV_BITS     = $clog2(P_CLKS_PER_PIXEL);
    localparam int COL_IDX_BITS = $clog2(P_H_ACTIVE);

    localparam logic [DIV_BITS-1:0]      DIV_LAST     = DIV_BITS'(P_CLKS_PER_PIXEL - 1);
    localparam logic [DIV_BITS-1:0]      DIV_HALF     = DIV_BITS'(P_CLKS_PER_PIXEL / 2);
    localparam logic [P_COLUMN_BITS-1:0] H_LAST       = P_COLUMN_BITS'(H_TOTAL - 1);
    localparam logic [P_COLUMN_BITS-1:0] H_ACT        = P_COLUMN_BITS'(P_H_ACTIVE);
    localparam logic [P_COLUMN_BITS-1:0] H_ACT_LAST   = P_COLUMN_BITS'(P_H_ACTIVE - 1);
    localparam logic [P_COLUMN_BITS-1:0] H_SYNC_START = P_COLUMN_BITS'(P_H_ACTIVE + P_H_FRONT);
    localparam logic [P_COLUMN_BITS-1:0] H_SYNC_END   = P_COLUMN_BITS'(P_H_ACTIVE + P_H_FRONT + P_H_SYNC);
    localparam logic [P_ROW_BITS-1:0]    V_LAST       = P_ROW_BITS'(V_TOTAL - 1);
    localparam logic [P_ROW_BITS-1:0]    V_ACT        = P_ROW_BITS'(P_V_ACTIVE);
    localparam logic [P_ROW_BITS-1:0]    V_SYNC_START = P_ROW_BITS'(P_V_ACTIVE + P_V_FRONT);
    localparam logic [P_ROW_BITS-1:0]    V_SYNC_END   = P_ROW_BITS'(P_V_ACTIVE + P_V_FRONT + P_V_SYNC);

    logic [DIV_BITS-1:0]             div_q, div_d;
    logic [P_COLUMN_BITS-1:0]        h_q, h_d;
    logic [P_ROW_BITS-1:0]           v_q, v_d;
    logic                            pixel_clk_q, pixel_clk_d;
    logic                            hsync_q, hsync_d;
    logic                            vsync_q, vsync_d;
    logic                            data_valid_q, data_valid_d;
    logic [3*P_SUBPIXEL_DEPTH-1:0]   pixel_q, pixel_d;
    logic                            frame_start_q, frame_start_d;
    logic                            underflow_q, underflow_d;
    logic                            line_ok_q, line_ok_d;
    logic [P_ROW_BITS-1:0]           tag_q [2];
    logic [P_ROW_BITS-1:0]           tag_d [2];
    logic [1:0]                      tag_valid_q, tag_valid_d;

    logic [P_SUBPIXEL_DEPTH-1:0]     mem_q [2][P_H_ACTIVE];
    logic                            mem_wr_en;
    logic                            wr_slot;
    logic [COL_IDX_BITS-1:0]         wr_idx;
    logic [COL_IDX_BITS-1:0]         rd_idx;
    logic [P_SUBPIXEL_DEPTH-1:0]     rd_data;
    logic                            tick;
    logic                            active;
    logic                            line_check;
    logic                            line_ok_now;
    logic                            underflow_set;

    // Next-state logic: pixel divider, raster counters, stream outputs, line tags and underflow flag
    always_comb begin
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        data_valid_d  = data_valid_q;
        pixel_d       = pixel_q;
        line_ok_d     = line_ok_q;
        tag_d         = tag_q;
        tag_valid_d   = tag_valid_q;
        frame_start_d = 1'b0;
        underflow_set = 1'b0;
        line_ok_now   = line_ok_q;

        tick        = I_ENABLE && (div_q == DIV_LAST);
        pixel_clk_d = (div_q >= DIV_HALF);
        active      = (h_q < H_ACT) && (v_q < V_ACT);
        rd_idx      = active ? h_q[COL_IDX_BITS-1:0] : '0;
        rd_data     = mem_q[v_q[0]][rd_idx];
        line_check  = tag_valid_q[v_q[0]] && (tag_q[v_q[0]] == v_q);

        mem_wr_en = !I_RESET && pix_bus.I_PIXEL_VALID
                    && (pix_bus.I_PIXEL_COLUMN < H_ACT) && (pix_bus.I_PIXEL_ROW < V_ACT);
        wr_slot   = pix_bus.I_PIXEL_ROW[0];
        wr_idx    = pix_bus.I_PIXEL_COLUMN[COL_IDX_BITS-1:0];
        if (mem_wr_en && (pix_bus.I_PIXEL_COLUMN == H_ACT_LAST)) begin
            tag_d[wr_slot]       = pix_bus.I_PIXEL_ROW;
            tag_valid_d[wr_slot] = 1'b1;
        end

        if (!I_ENABLE) begin
            hsync_d      = 1'b1;
            vsync_d      = 1'b1;
            data_valid_d = 1'b0;
            pixel_d      = '0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                if ((h_q == '0) && (v_q < V_ACT)) begin
                    line_ok_now   = line_check;
                    line_ok_d     = line_check;
                    underflow_set = !line_check;
                end
                hsync_d       = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
                vsync_d       = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
                data_valid_d  = active;
                pixel_d       = (active && line_ok_now) ? {3{rd_data}} : '0;
                frame_start_d = (h_q == '0) && (v_q == '0);
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
        end

        underflow_d = underflow_set ? 1'b1 : (I_CLEAR_UNDERFLOW ? 1'b0 : underflow_q);
    end

    // State registers with synchronous reset; reset aborts any frame in progress
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            pixel_clk_q   <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            data_valid_q  <= 1'b0;
            pixel_q       <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            line_ok_q     <= 1'b0;
            tag_q         <= '{default: '0};
            tag_valid_q   <= '0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pixel_clk_q   <= pixel_clk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            data_valid_q  <= data_valid_d;
            pixel_q       <= pixel_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            line_ok_q     <= line_ok_d;
            tag_q         <= tag_d;
            tag_valid_q   <= tag_valid_d;
        end
    end

    // Two-line ping-pong store; a read of the slot being written sees the old pixel
    always_ff @(posedge I_CLK) begin
        if (mem_wr_en) begin
            mem_q[wr_slot][wr_idx] <= pix_bus.I_PIXEL;
        end
    end

    assign O_PIXEL_CLK   = pixel_clk_q;
    assign O_HSYNC       = hsync_q;
    assign O_VSYNC       = vsync_q;
    assign O_DATA_VALID  = data_valid_q;
    assign O_PIXEL       = pixel_q;
    assign O_FRAME_START = frame_start_q;
    assign O_UNDERFLOW   = underflow_q;
endmodule

// File: tb/tb_vga_grayscale_frame_transmitter.sv
// Self-checking bench for the VGA grayscale frame transmitter, run on a reduced raster
// so several frames fit in a short simulation. A behavioural raster model predicts every output.
module tb_vga_grayscale_frame_transmitter;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 8, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int CPP = 2;
    localparam int CB = $clog2(HT);
    localparam int RB = $clog2(VT);

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic        I_ENABLE;
    logic        I_CLEAR_UNDERFLOW;
    logic        O_PIXEL_CLK, O_HSYNC, O_VSYNC, O_DATA_VALID, O_FRAME_START, O_UNDERFLOW;
    logic [23:0] O_PIXEL;

    vga_grayscale_frame_transmitter_if #(.P_COLUMN_BITS(CB), .P_ROW_BITS(RB), .P_SUBPIXEL_DEPTH(8)) pix_bus ();

    vga_grayscale_frame_transmitter #(
        .P_H_ACTIVE(HA), .P_H_FRONT(HF), .P_H_SYNC(HS), .P_H_BACK(HB),
        .P_V_ACTIVE(VA), .P_V_FRONT(VF), .P_V_SYNC(VS), .P_V_BACK(VB),
        .P_CLKS_PER_PIXEL(CPP), .P_SUBPIXEL_DEPTH(8),
        .P_COLUMN_BITS(CB), .P_ROW_BITS(RB)
    ) dut (
        .I_CLK(I_CLK),
        .I_RESET(I_RESET),
        .I_ENABLE(I_ENABLE),
        .I_CLEAR_UNDERFLOW(I_CLEAR_UNDERFLOW),
        .pix_bus(pix_bus),
        .O_PIXEL_CLK(O_PIXEL_CLK),
        .O_HSYNC(O_HSYNC),
        .O_VSYNC(O_VSYNC),
        .O_DATA_VALID(O_DATA_VALID),
        .O_PIXEL(O_PIXEL),
        .O_FRAME_START(O_FRAME_START),
        .O_UNDERFLOW(O_UNDERFLOW)
    );

    // Free-running system clock
    always #5 I_CLK = ~I_CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: raster position, line store, line tags and predicted outputs
    int        mdiv, mh, mv;
    bit        mok;
    bit [7:0]  mmem [2][HA];
    int        mtag [2];
    bit        mtv  [2];
    bit        ticked;
    int        out_h, out_v;
    logic      e_pclk, e_hs, e_vs, e_dv, e_fs, e_uf;
    logic [23:0] e_pix;
    bit [7:0]  rowdata [VA][HA];

    task automatic checkOutput(input string name, input logic [23:0] obs, input logic [23:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare
    task automatic cycle();
        bit uf_set;
        int c, r;
        uf_set = 1'b0;
        @(posedge I_CLK);
        ticked = 1'b0;
        if (I_RESET) begin
            mdiv = 0; mh = 0; mv = 0; mok = 1'b0;
            mtv[0] = 1'b0; mtv[1] = 1'b0;
            e_pclk = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_dv = 1'b0;
            e_pix = '0; e_fs = 1'b0; e_uf = 1'b0;
        end else begin
            e_pclk = (mdiv >= CPP / 2);
            e_fs = 1'b0;
            if (!I_ENABLE) begin
                e_hs = 1'b1; e_vs = 1'b1; e_dv = 1'b0; e_pix = '0;
            end else if (mdiv == CPP - 1) begin
                mdiv = 0;
                if (mh == 0 && mv < VA) begin
                    mok = mtv[mv % 2] && (mtag[mv % 2] == mv);
                    uf_set = !mok;
                end
                e_hs  = !(mh >= HA + HF && mh < HA + HF + HS);
                e_vs  = !(mv >= VA + VF && mv < VA + VF + VS);
                e_dv  = (mh < HA) && (mv < VA);
                e_pix = '0;
                if (e_dv && mok) e_pix = {3{mmem[mv % 2][mh]}};
                e_fs  = (mh == 0) && (mv == 0);
                ticked = 1'b1; out_h = mh; out_v = mv;
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end
            end else begin
                mdiv++;
            end
            if (uf_set) e_uf = 1'b1;
            else if (I_CLEAR_UNDERFLOW) e_uf = 1'b0;
            c = int'(pix_bus.I_PIXEL_COLUMN);
            r = int'(pix_bus.I_PIXEL_ROW);
            if (pix_bus.I_PIXEL_VALID && c < HA && r < VA) begin
                mmem[r % 2][c] = pix_bus.I_PIXEL;
                if (c == HA - 1) begin
                    mtag[r % 2] = r;
                    mtv[r % 2] = 1'b1;
                end
            end
        end
        #1;
        checkOutput("pixel_clk", O_PIXEL_CLK, e_pclk);
        checkOutput("hsync", O_HSYNC, e_hs);
        checkOutput("vsync", O_VSYNC, e_vs);
        checkOutput("data_valid", O_DATA_VALID, e_dv);
        checkOutput("pixel", O_PIXEL, e_pix);
        checkOutput("frame_start", O_FRAME_START, e_fs);
        checkOutput("underflow", O_UNDERFLOW, e_uf);
    endtask

    task automatic applyStimulus(input bit en, input bit pv, input int col, input int row,
                                 input bit [7:0] pix, input bit clr);
        I_ENABLE                = en;
        pix_bus.I_PIXEL_VALID   = pv;
        pix_bus.I_PIXEL_COLUMN  = CB'(col);
        pix_bus.I_PIXEL_ROW     = RB'(row);
        pix_bus.I_PIXEL         = pix;
        I_CLEAR_UNDERFLOW       = clr;
        cycle();
    endtask

    // Run enabled until the model reports that position (h,v) was just output
    task automatic waitTick(input int h, input int v, input int limit, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
            found = ticked && out_h == h && out_v == v;
        end
        checkOutput(name, found, 1'b1);
    endtask

    // Directed sequence followed by a randomized soak
    initial begin
        int n, hs_low, vs_low;
        bit found;
        for (int r = 0; r < VA; r++)
            for (int c = 0; c < HA; c++)
                rowdata[r][c] = (r < 2) ? 8'(c) : 8'($urandom_range(0, 255));

        I_RESET = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 0, 8'd0, 1'b0);
        checkOutput("reset_hsync", O_HSYNC, 1'b1);
        checkOutput("reset_vsync", O_VSYNC, 1'b1);
        checkOutput("reset_pixel", O_PIXEL, 24'h0);
        checkOutput("reset_underflow", O_UNDERFLOW, 1'b0);
        I_RESET = 1'b0;

        $display("[TB] filling rows 0 and 1 with gray = column");
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < HA; c++)
                applyStimulus(1'b0, 1'b1, c, r, rowdata[r][c], 1'b0);

        waitTick(5, 0, 100, "reach_r0c5");
        checkOutput("r0c5_pixel", O_PIXEL, 24'h050505);
        checkOutput("r0c5_valid", O_DATA_VALID, 1'b1);

        waitTick(0, 2, 2000, "reach_r2c0");
        checkOutput("r2_pixel_black", O_PIXEL, 24'h0);
        checkOutput("r2_valid", O_DATA_VALID, 1'b1);
        checkOutput("r2_underflow", O_UNDERFLOW, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
        checkOutput("underflow_sticky", O_UNDERFLOW, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b1);
        checkOutput("underflow_cleared", O_UNDERFLOW, 1'b0);

        $display("[TB] writing rows 3 and 4 ahead of display");
        for (int r = 3; r < 5; r++)
            for (int c = 0; c < HA; c++)
                applyStimulus(1'b1, 1'b1, c, r, rowdata[r][c], 1'b0);
        waitTick(5, 4, 400, "reach_r4c5");
        checkOutput("r4c5_pixel", O_PIXEL, {3{rowdata[4][5]}});
        checkOutput("r4_no_underflow", O_UNDERFLOW, 1'b0);

        waitTick(1, 1, 2000, "reach_f2_r1c1");
        applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b1);
        for (int c = 0; c < HA - 1; c++)
            applyStimulus(1'b1, 1'b1, c, 2, rowdata[2][c], 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            found = (mdiv == CPP - 1 && mh == 0 && mv == 2);
            if (!found) applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
        end
        checkOutput("reach_collision", found, 1'b1);
        checkOutput("uf_before_collision", O_UNDERFLOW, 1'b0);
        applyStimulus(1'b1, 1'b1, HA - 1, 2, rowdata[2][HA - 1], 1'b0);
        checkOutput("collision_underflow", O_UNDERFLOW, 1'b1);
        checkOutput("collision_pixel", O_PIXEL, 24'h0);

        waitTick(9, 3, 400, "reach_r3c9");
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 0, 0, 8'd0, 1'b0);
        checkOutput("paused_hsync", O_HSYNC, 1'b1);
        checkOutput("paused_valid", O_DATA_VALID, 1'b0);
        checkOutput("paused_pixel", O_PIXEL, 24'h0);
        waitTick(10, 3, 10, "resume_r3c10");
        checkOutput("resume_pixel", O_PIXEL, {3{rowdata[3][10]}});

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
            found = (O_FRAME_START === 1'b1);
        end
        checkOutput("frame_start_seen", found, 1'b1);
        n = 0; hs_low = 0; vs_low = 0; found = 1'b0;
        while (n < 2000 && !found) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
            n++;
            if (O_HSYNC === 1'b0) hs_low++;
            if (O_VSYNC === 1'b0) vs_low++;
            found = (O_FRAME_START === 1'b1);
        end
        checkOutput("frame_period", 24'(n), 24'(HT * VT * CPP));
        checkOutput("hsync_low_cycles", 24'(hs_low), 24'(HS * VT * CPP));
        checkOutput("vsync_low_cycles", 24'(vs_low), 24'(VS * HT * CPP));

        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
        checkOutput("uf_before_reset", O_UNDERFLOW, 1'b1);
        I_RESET = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
        checkOutput("midreset_vsync", O_VSYNC, 1'b1);
        checkOutput("midreset_valid", O_DATA_VALID, 1'b0);
        checkOutput("midreset_underflow", O_UNDERFLOW, 1'b0);
        checkOutput("midreset_pclk", O_PIXEL_CLK, 1'b0);
        I_RESET = 1'b0;
        applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 0, 8'd0, 1'b0);
        checkOutput("restart_frame_start", O_FRAME_START, 1'b1);

        $display("[TB] randomized soak");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, HT - 1), $urandom_range(0, VT - 1),
                          8'($urandom_range(0, 255)), $urandom_range(0, 29) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
